// File: rtl/l2_xbar_pkg.sv
// ---------------------------------------------------------------------------
// l2_xbar_pkg
// Shared types and constants for the L2 TCDM crossbar.
//   tcdm_req_t : one lint request beat (req, word/byte address, wen, be, wdata)
//   tcdm_rsp_t : one lint response beat (gnt, r_valid, r_rdata, r_opc)
//   ERR_RDATA  : read data returned with an error response
// ---------------------------------------------------------------------------
package l2_xbar_pkg;

    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

    typedef struct packed {
        logic        req;
        logic [31:0] add;
        logic        wen;     // 1 = read, 0 = write
        logic [3:0]  be;
        logic [31:0] wdata;
    } tcdm_req_t;

    typedef struct packed {
        logic        gnt;
        logic        r_valid;
        logic [31:0] r_rdata;
        logic        r_opc;   // 1 = error
    } tcdm_rsp_t;

    // Width of an index into n items, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// l2_rr_arbiter
// N-input round-robin arbiter with a registered priority pointer.
// The search for a winner starts at ptr_reg; after a grant to input k the
// pointer moves to (k+1) mod N, otherwise it holds.
//   clk   : clock
//   rst   : asynchronous active-high reset (pointer -> 0)
//   req_i : request vector
//   gnt_o : one-hot grant vector (all zero when no request), combinational
// ---------------------------------------------------------------------------
module l2_rr_arbiter
    import l2_xbar_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned PW = idx_width(N);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;

    always_comb begin
        logic          found;
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        gnt_o    = '0;
        ptr_next = ptr_reg;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < int'(N); i++) begin
            // Candidate (ptr + i) mod N, computed one bit wider to catch wrap.
            sum = {1'b0, ptr_reg} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_next   = (idx == PW'(N-1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/l2_tcdm_xbar.sv
// ---------------------------------------------------------------------------
// l2_tcdm_xbar
// Crossbar between NB_MASTERS lint masters and NB_BANKS single-cycle L2 SRAM
// banks. Words are interleaved across banks; each bank has its own
// round-robin arbiter. Grants are combinational, responses come exactly one
// cycle after the grant and are routed through per-master registers.
// Addresses beyond the mapped range are granted without touching a bank
// and answered with an error response.
//
// Ports
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   mst_req_i/add/wen/be/wdata : master request channel (wen: 1 = read)
//   mst_gnt_o             : grant, same cycle as request
//   mst_r_valid_o/rdata/opc: response channel (opc: 1 = error)
//   bank_req_o/add/wen/be/wdata: bank request channel (word address)
//   bank_rdata_i          : bank read data, one cycle after bank_req_o
// ---------------------------------------------------------------------------
module l2_tcdm_xbar
    import l2_xbar_pkg::*;
#(
    parameter int unsigned NB_MASTERS = 2,
    parameter int unsigned NB_BANKS   = 4,
    parameter int unsigned BANK_WORDS = 8192,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BANK_AW    = $clog2(BANK_WORDS)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NB_MASTERS-1:0]                 mst_req_i,
    input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0] mst_add_i,
    input  logic [NB_MASTERS-1:0]                 mst_wen_i,
    input  logic [NB_MASTERS-1:0][3:0]            mst_be_i,
    input  logic [NB_MASTERS-1:0][31:0]           mst_wdata_i,
    output logic [NB_MASTERS-1:0]                 mst_gnt_o,
    output logic [NB_MASTERS-1:0]                 mst_r_valid_o,
    output logic [NB_MASTERS-1:0][31:0]           mst_r_rdata_o,
    output logic [NB_MASTERS-1:0]                 mst_r_opc_o,
    output logic [NB_BANKS-1:0]                   bank_req_o,
    output logic [NB_BANKS-1:0][BANK_AW-1:0]      bank_add_o,
    output logic [NB_BANKS-1:0]                   bank_wen_o,
    output logic [NB_BANKS-1:0][3:0]              bank_be_o,
    output logic [NB_BANKS-1:0][31:0]             bank_wdata_o,
    input  logic [NB_BANKS-1:0][31:0]             bank_rdata_i
);

    localparam int unsigned LOG2B   = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 0;
    localparam int unsigned BIDX_W  = idx_width(NB_BANKS);
    // First byte-address bit that lies outside the mapped L2 range.
    localparam int unsigned TOP_BIT = 2 + LOG2B + BANK_AW;

    // ------------------------------------------------------------------
    // Address decode per master
    // ------------------------------------------------------------------
    logic [NB_MASTERS-1:0][BIDX_W-1:0]  bank_idx;
    logic [NB_MASTERS-1:0][BANK_AW-1:0] word_addr;
    logic [NB_MASTERS-1:0]              oor;
    logic [NB_MASTERS-1:0][1:0]         unused_addr_lsbs;

    genvar gi, gj;

    generate
        for (gi = 0; gi < int'(NB_MASTERS); gi++) begin : g_dec
            if (NB_BANKS > 1) begin : g_idx
                assign bank_idx[gi] = mst_add_i[gi][2 +: LOG2B];
            end else begin : g_idx1
                assign bank_idx[gi] = '0;
            end

            assign word_addr[gi] = mst_add_i[gi][2+LOG2B +: BANK_AW];

            if (TOP_BIT < ADDR_WIDTH) begin : g_oor
                assign oor[gi] = |mst_add_i[gi][ADDR_WIDTH-1:TOP_BIT];
            end else begin : g_no_oor
                assign oor[gi] = 1'b0;
            end

            // Byte offset inside the 32-bit word is not used by the banks.
            assign unused_addr_lsbs[gi] = mst_add_i[gi][1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-bank request matrix, arbitration and payload mux
    // ------------------------------------------------------------------
    logic [NB_BANKS-1:0][NB_MASTERS-1:0] bank_req_mat;
    logic [NB_BANKS-1:0][NB_MASTERS-1:0] bank_gnt_mat;

    generate
        for (gi = 0; gi < int'(NB_BANKS); gi++) begin : g_bank
            for (gj = 0; gj < int'(NB_MASTERS); gj++) begin : g_rm
                assign bank_req_mat[gi][gj] = mst_req_i[gj] & ~oor[gj]
                                            & (bank_idx[gj] == BIDX_W'(gi));
            end

            l2_rr_arbiter #(
                .N (NB_MASTERS)
            ) u_arb (
                .clk   (clk_i),
                .rst   (rst_i),
                .req_i (bank_req_mat[gi]),
                .gnt_o (bank_gnt_mat[gi])
            );

            tcdm_req_t sel;

            // Grant is one-hot, so the OR-style mux never merges two masters.
            always_comb begin
                sel = '0;
                for (int m = 0; m < int'(NB_MASTERS); m++) begin
                    if (bank_gnt_mat[gi][m]) begin
                        sel.req   = 1'b1;
                        sel.add   = 32'(word_addr[m]);
                        sel.wen   = mst_wen_i[m];
                        sel.be    = mst_be_i[m];
                        sel.wdata = mst_wdata_i[m];
                    end
                end
            end

            assign bank_req_o[gi]   = sel.req;
            assign bank_add_o[gi]   = sel.add[BANK_AW-1:0];
            assign bank_wen_o[gi]   = sel.wen;
            assign bank_be_o[gi]    = sel.be;
            assign bank_wdata_o[gi] = sel.wdata;

            if (BANK_AW < 32) begin : g_add_pad
                logic [31-BANK_AW:0] unused_add_pad;
                assign unused_add_pad = sel.add[31:BANK_AW];
            end
        end
    endgenerate

    // Collapse the bank grant matrix into one hit bit per master.
    logic [NB_MASTERS-1:0] mst_bank_hit;

    always_comb begin
        mst_bank_hit = '0;
        for (int b = 0; b < int'(NB_BANKS); b++) begin
            mst_bank_hit = mst_bank_hit | bank_gnt_mat[b];
        end
    end

    // ------------------------------------------------------------------
    // Per-master grant and registered response routing
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < int'(NB_MASTERS); gi++) begin : g_mst
            logic              pending_reg;
            logic              err_reg;
            logic              wr_reg;
            logic [BIDX_W-1:0] bank_reg;
            tcdm_rsp_t         rsp;

            always_comb begin
                rsp         = '0;
                // Out-of-range requests never compete for a bank.
                rsp.gnt     = (mst_req_i[gi] & oor[gi]) | mst_bank_hit[gi];
                rsp.r_valid = pending_reg;
                rsp.r_opc   = pending_reg & err_reg;
                if (pending_reg) begin
                    if (err_reg) begin
                        rsp.r_rdata = ERR_RDATA;
                    end else if (wr_reg) begin
                        rsp.r_rdata = 32'h0;
                    end else begin
                        rsp.r_rdata = bank_rdata_i[bank_reg];
                    end
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    pending_reg <= 1'b0;
                    err_reg     <= 1'b0;
                    wr_reg      <= 1'b0;
                    bank_reg    <= '0;
                end else begin
                    pending_reg <= rsp.gnt;
                    if (rsp.gnt) begin
                        err_reg  <= oor[gi];
                        wr_reg   <= ~mst_wen_i[gi];
                        bank_reg <= bank_idx[gi];
                    end
                end
            end

            assign mst_gnt_o[gi]     = rsp.gnt;
            assign mst_r_valid_o[gi] = rsp.r_valid;
            assign mst_r_rdata_o[gi] = rsp.r_rdata;
            assign mst_r_opc_o[gi]   = rsp.r_opc;
        end
    endgenerate

endmodule

// File: tb/tb_l2_tcdm_xbar.sv
// ---------------------------------------------------------------------------
// tb_l2_tcdm_xbar
// Directed bench for l2_tcdm_xbar with 2 masters and 4 banks of 8192 words.
// A behavioural single-cycle SRAM per bank answers bank requests; words
// never written read back as a fixed pattern derived from bank and address.
// ---------------------------------------------------------------------------
module tb_l2_tcdm_xbar;

    localparam int NM = 2;
    localparam int NB = 4;
    localparam int BW = 8192;
    localparam int AW = 13;

    logic                clk;
    logic                rst;
    logic [NM-1:0]       mst_req;
    logic [NM-1:0][31:0] mst_add;
    logic [NM-1:0]       mst_wen;
    logic [NM-1:0][3:0]  mst_be;
    logic [NM-1:0][31:0] mst_wdata;
    logic [NM-1:0]       mst_gnt;
    logic [NM-1:0]       mst_r_valid;
    logic [NM-1:0][31:0] mst_r_rdata;
    logic [NM-1:0]       mst_r_opc;
    logic [NB-1:0]       bank_req;
    logic [NB-1:0][AW-1:0] bank_add;
    logic [NB-1:0]       bank_wen;
    logic [NB-1:0][3:0]  bank_be;
    logic [NB-1:0][31:0] bank_wdata;
    logic [NB-1:0][31:0] bank_rdata;

    int tests_run;
    int tests_failed;

    l2_tcdm_xbar #(
        .NB_MASTERS (NM),
        .NB_BANKS   (NB),
        .BANK_WORDS (BW),
        .ADDR_WIDTH (32)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .mst_req_i     (mst_req),
        .mst_add_i     (mst_add),
        .mst_wen_i     (mst_wen),
        .mst_be_i      (mst_be),
        .mst_wdata_i   (mst_wdata),
        .mst_gnt_o     (mst_gnt),
        .mst_r_valid_o (mst_r_valid),
        .mst_r_rdata_o (mst_r_rdata),
        .mst_r_opc_o   (mst_r_opc),
        .bank_req_o    (bank_req),
        .bank_add_o    (bank_add),
        .bank_wen_o    (bank_wen),
        .bank_be_o     (bank_be),
        .bank_wdata_o  (bank_wdata),
        .bank_rdata_i  (bank_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin pointers of the four bank arbiters, bank 3 in the MSB.
    logic [3:0] ptr_vec;
    assign ptr_vec = {dut.g_bank[3].u_arb.ptr_reg, dut.g_bank[2].u_arb.ptr_reg,
                      dut.g_bank[1].u_arb.ptr_reg, dut.g_bank[0].u_arb.ptr_reg};

    // ---------------- bank SRAM model ----------------
    logic [31:0] mem     [NB][BW];
    logic        written [NB][BW];

    function automatic logic [31:0] pat(input int b, input int w);
        return 32'hA500_0000 | (32'(b) << 16) | 32'(w);
    endfunction

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_req[b]) begin
                if (!bank_wen[b]) begin
                    for (int k = 0; k < 4; k++) begin
                        if (bank_be[b][k]) begin
                            mem[b][bank_add[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
                        end
                    end
                    written[b][bank_add[b]] <= 1'b1;
                end
                bank_rdata[b] <= written[b][bank_add[b]] ? mem[b][bank_add[b]]
                                                         : pat(b, int'(bank_add[b]));
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mst_req   = '0;
        mst_add   = '0;
        mst_wen   = '1;
        mst_be    = '0;
        mst_wdata = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [1:0] exp_gnt;
        tests_run    = 0;
        tests_failed = 0;
        for (int b = 0; b < NB; b++) begin
            for (int w = 0; w < BW; w++) begin
                written[b][w] = 1'b0;
            end
            bank_rdata[b] = '0;
        end
        rst = 1'b1;
        idle();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_r_valid", 32'(mst_r_valid), 32'h0);
        chk("rst_r_opc",   32'(mst_r_opc),   32'h0);
        chk("rst_rdata0",  mst_r_rdata[0],   32'h0);
        chk("rst_rdata1",  mst_r_rdata[1],   32'h0);
        chk("rst_ptr",     32'(ptr_vec),     32'h0);
        chk("rst_bank_req",32'(bank_req),    32'h0);
        chk("rst_gnt",     32'(mst_gnt),     32'h0);
        $display("[TB] reset checked");

        // M0 write 0xDEADBEEF to 0x4 -> bank 1, word 0
        mst_req[0] = 1'b1; mst_add[0] = 32'h4; mst_wen[0] = 1'b0;
        mst_be[0] = 4'hF; mst_wdata[0] = 32'hDEADBEEF;
        #1;
        chk("wr_gnt",       32'(mst_gnt),      32'h1);
        chk("wr_bank_req",  32'(bank_req),     32'h2);
        chk("wr_bank_add",  32'(bank_add[1]),  32'h0);
        chk("wr_bank_wen",  32'(bank_wen[1]),  32'h0);
        chk("wr_bank_wdata",bank_wdata[1],     32'hDEADBEEF);
        tick();
        chk("wr_r_valid",   32'(mst_r_valid),  32'h1);
        chk("wr_r_opc",     32'(mst_r_opc),    32'h0);
        chk("wr_rdata",     mst_r_rdata[0],    32'h0);
        chk("wr_mem",       mem[1][0],         32'hDEADBEEF);
        $display("[TB] M0 write 0x4 <= DEADBEEF");

        // Back-to-back read of the same word
        mst_wen[0] = 1'b1;
        #1;
        chk("rd_gnt",       32'(mst_gnt),      32'h1);
        tick();
        chk("rd_r_valid",   32'(mst_r_valid),  32'h1);
        chk("rd_r_opc",     32'(mst_r_opc),    32'h0);
        chk("rd_rdata",     mst_r_rdata[0],    32'hDEADBEEF);
        $display("[TB] M0 read 0x4 => %h", mst_r_rdata[0]);
        idle();

        // Both masters hammer 0x10 (bank 0, word 1) for 4 cycles
        mst_req = 2'b11; mst_add[0] = 32'h10; mst_add[1] = 32'h10; mst_wen = 2'b11;
        for (int c = 0; c < 4; c++) begin
            exp_gnt = (c % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            chk("rr_gnt",     32'(mst_gnt),     32'(exp_gnt));
            tick();
            chk("rr_r_valid", 32'(mst_r_valid), 32'(exp_gnt));
            chk("rr_rdata",   mst_r_rdata[(c % 2 == 0) ? 0 : 1], pat(0, 1));
            $display("[TB] contention cycle %0d gnt=%b", c, exp_gnt);
        end
        idle();

        // Different banks in the same cycle
        mst_req = 2'b11; mst_add[0] = 32'h0; mst_add[1] = 32'h4; mst_wen = 2'b11;
        #1;
        chk("par_gnt",      32'(mst_gnt),      32'h3);
        chk("par_bank_req", 32'(bank_req),     32'h3);
        tick();
        chk("par_r_valid",  32'(mst_r_valid),  32'h3);
        chk("par_rdata0",   mst_r_rdata[0],    pat(0, 0));
        chk("par_rdata1",   mst_r_rdata[1],    32'hDEADBEEF);
        $display("[TB] parallel M0@0x0 M1@0x4");
        idle();

        // Out-of-range read
        mst_req[0] = 1'b1; mst_add[0] = 32'h0002_0000; mst_wen[0] = 1'b1;
        #1;
        chk("oor_gnt",      32'(mst_gnt),      32'h1);
        chk("oor_bank_req", 32'(bank_req),     32'h0);
        tick();
        chk("oor_r_valid",  32'(mst_r_valid),  32'h1);
        chk("oor_r_opc",    32'(mst_r_opc),    32'h1);
        chk("oor_rdata",    mst_r_rdata[0],    32'hBADACCE5);
        $display("[TB] out-of-range read 0x20000");
        idle();

        // Reset during the grant cycle of a read
        #1;
        chk("pre_rst_ptr",  32'(ptr_vec),      32'h1);
        mst_req[0] = 1'b1; mst_add[0] = 32'h0; mst_wen[0] = 1'b1;
        rst = 1'b1;
        #1;
        chk("rstg_gnt",     32'(mst_gnt),      32'h1);
        chk("rstg_ptr",     32'(ptr_vec),      32'h0);
        tick();
        idle();
        chk("rstg_r_valid", 32'(mst_r_valid),  32'h0);
        rst = 1'b0;
        tick();
        chk("post_r_valid", 32'(mst_r_valid),  32'h0);
        chk("post_ptr",     32'(ptr_vec),      32'h0);
        $display("[TB] reset in grant cycle");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
